// File: rtl/decode_seq_stage_if.sv
// Purpose: fetch-to-decode handshake plus the registered decode result bus.
// Latency: none, this is wiring only.
// Backpressure: in_valid/in_ready from fetch; stall/flush come from downstream control.
// Ports: master = fetch/control side (drives instr, pc_in, stall, flush),
//        slave  = decode stage (drives in_ready and all decoded outputs).
interface decode_seq_stage_if #(
    parameter int PC_W      = 16,
    parameter int IMM_OUT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          instr;
    logic [PC_W-1:0]      pc_in;
    logic                 stall;
    logic                 flush;
    logic                 out_valid;
    logic [4:0]           opertn;
    logic [2:0]           RA;
    logic [2:0]           RB;
    logic [2:0]           RC;
    logic                 check_c;
    logic                 check_z;
    logic                 do_comp;
    logic                 check_imm;
    logic [IMM_OUT_W-1:0] imm_value;
    logic [PC_W-1:0]      pc_out;
    logic                 uop_last;
    logic                 illegal;

    modport master (
        output in_valid, instr, pc_in, stall, flush,
        input  in_ready, out_valid, opertn, RA, RB, RC, check_c, check_z,
               do_comp, check_imm, imm_value, pc_out, uop_last, illegal
    );

    modport slave (
        input  in_valid, instr, pc_in, stall, flush,
        output in_ready, out_valid, opertn, RA, RB, RC, check_c, check_z,
               do_comp, check_imm, imm_value, pc_out, uop_last, illegal
    );
endinterface

// File: rtl/decode_seq_stage.sv
// Purpose: decode stage; registers decoded control fields and expands LM/SM into per-register micro-ops.
// Latency: 1 cycle from accept to output; LM/SM micro-ops start 1 cycle after accept, one per cycle.
// Backpressure: in_ready = !stall && IDLE; stall freezes all registers; flush kills output and sequence.
// Ports: clk, rst_n (async active-low), bus (slave side of decode_seq_stage_if).
module decode_seq_stage #(
    parameter int PC_W      = 16,
    parameter int IMM_OUT_W = 16,
    parameter bit SEXT_IMM  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_seq_stage_if.slave    bus
);
    localparam logic [4:0] OP_LM      = 5'd18;
    localparam logic [4:0] OP_SM      = 5'd19;
    localparam logic [4:0] OP_ILLEGAL = 5'h1F;

    typedef enum logic {IDLE, SEQ} state_t;

    typedef struct packed {
        logic [4:0]           opertn;
        logic [2:0]           ra;
        logic [2:0]           rb;
        logic [2:0]           rc;
        logic                 check_c;
        logic                 check_z;
        logic                 do_comp;
        logic                 check_imm;
        logic [IMM_OUT_W-1:0] imm;
        logic                 illegal;
    } dec_t;

    state_t               state;
    logic [7:0]           seq_mask;   // registers still to be emitted
    logic [2:0]           seq_k;      // micro-ops already emitted
    logic [2:0]           seq_base;
    logic                 seq_is_sm;
    logic [PC_W-1:0]      seq_pc;

    dec_t                 dec;
    logic [3:0]           op;
    logic [2:0]           r1, r2, r3, func;
    logic [1:0]           sub;
    logic [IMM_OUT_W-1:0] imm6, imm9;
    logic                 is_multi;
    logic [2:0]           sel;
    logic [7:0]           mask_rest;
    logic                 seq_last;

    assign bus.in_ready = !bus.stall && (state == IDLE);

    assign op   = bus.instr[15:12];
    assign r1   = bus.instr[11:9];
    assign r2   = bus.instr[8:6];
    assign r3   = bus.instr[5:3];
    assign func = bus.instr[2:0];
    assign imm6 = SEXT_IMM ? {{(IMM_OUT_W-6){bus.instr[5]}}, bus.instr[5:0]}
                           : {{(IMM_OUT_W-6){1'b0}}, bus.instr[5:0]};
    assign imm9 = SEXT_IMM ? {{(IMM_OUT_W-9){bus.instr[8]}}, bus.instr[8:0]}
                           : {{(IMM_OUT_W-9){1'b0}}, bus.instr[8:0]};
    assign is_multi = (op == 4'b0110) || (op == 4'b0111);

    // Variant order within a family: unconditional, carry, zero, with-carry.
    always_comb begin
        sub = 2'd0;
        case (func[1:0])
            2'b00: sub = 2'd0;
            2'b10: sub = 2'd1;
            2'b01: sub = 2'd2;
            2'b11: sub = 2'd3;
            default: sub = 2'd0;
        endcase
    end

    always_comb begin
        dec = '0;
        case (op)
            4'b0000: begin  // ADI
                dec.opertn = 5'd0; dec.ra = r1; dec.rc = r2;
                dec.check_imm = 1'b1; dec.imm = imm6;
            end
            4'b0001: begin  // ADD family
                dec.opertn  = 5'd1 + 5'(sub) + (func[2] ? 5'd4 : 5'd0);
                dec.ra = r1; dec.rb = r2; dec.rc = r3;
                dec.do_comp = func[2];
                dec.check_c = (func[1:0] == 2'b10);
                dec.check_z = (func[1:0] == 2'b01);
            end
            4'b0010: begin  // NAND family; no with-carry variant exists
                if (func[1:0] == 2'b11) begin
                    dec.opertn = OP_ILLEGAL; dec.illegal = 1'b1;
                end else begin
                    dec.opertn  = 5'd9 + 5'(sub) + (func[2] ? 5'd3 : 5'd0);
                    dec.ra = r1; dec.rb = r2; dec.rc = r3;
                    dec.do_comp = func[2];
                    dec.check_c = (func[1:0] == 2'b10);
                    dec.check_z = (func[1:0] == 2'b01);
                end
            end
            4'b0011: begin  // LLI
                dec.opertn = 5'd15; dec.rc = r1; dec.check_imm = 1'b1; dec.imm = imm6;
            end
            4'b0100: begin  // LW
                dec.opertn = 5'd16; dec.rc = r1; dec.rb = r2;
                dec.check_imm = 1'b1; dec.imm = imm6;
            end
            4'b0101: begin  // SW
                dec.opertn = 5'd17; dec.ra = r1; dec.rb = r2;
                dec.check_imm = 1'b1; dec.imm = imm6;
            end
            4'b0110: dec.opertn = OP_LM;
            4'b0111: dec.opertn = OP_SM;
            4'b1000, 4'b1001, 4'b1010: begin  // BEQ, BLT, BLE
                dec.opertn = 5'd20 + 5'(op[1:0]);
                dec.ra = r1; dec.rb = r2; dec.imm = imm6;
            end
            4'b1100: begin  // JAL
                dec.opertn = 5'd23; dec.rc = r1; dec.check_imm = 1'b1; dec.imm = imm9;
            end
            4'b1101: begin  // JLR
                dec.opertn = 5'd24; dec.rc = r1; dec.rb = r2; dec.imm = imm6;
            end
            4'b1111: begin  // JRI
                dec.opertn = 5'd25; dec.ra = r1; dec.check_imm = 1'b1; dec.imm = imm9;
            end
            default: begin
                dec.opertn = OP_ILLEGAL; dec.illegal = 1'b1;
            end
        endcase
    end

    // Lowest-numbered register still pending; mask bit (7-i) selects Ri.
    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (seq_mask[7-i]) sel = 3'(i);
        end
        mask_rest = seq_mask & ~(8'h80 >> sel);
        seq_last  = (mask_rest == 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            seq_mask      <= '0;
            seq_k         <= '0;
            seq_base      <= '0;
            seq_is_sm     <= 1'b0;
            seq_pc        <= '0;
            bus.out_valid <= 1'b0;
            bus.opertn    <= '0;
            bus.RA        <= '0;
            bus.RB        <= '0;
            bus.RC        <= '0;
            bus.check_c   <= 1'b0;
            bus.check_z   <= 1'b0;
            bus.do_comp   <= 1'b0;
            bus.check_imm <= 1'b0;
            bus.imm_value <= '0;
            bus.pc_out    <= '0;
            bus.uop_last  <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
        end else if (!bus.stall) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && is_multi) begin
                        // LM/SM only latches the sequence; micro-ops come from SEQ.
                        bus.out_valid <= 1'b0;
                        seq_mask      <= bus.instr[7:0];
                        seq_k         <= 3'd0;
                        seq_base      <= r1;
                        seq_is_sm     <= op[0];
                        seq_pc        <= bus.pc_in;
                        if (bus.instr[7:0] != 8'h00) state <= SEQ;
                    end else if (bus.in_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.opertn    <= dec.opertn;
                        bus.RA        <= dec.ra;
                        bus.RB        <= dec.rb;
                        bus.RC        <= dec.rc;
                        bus.check_c   <= dec.check_c;
                        bus.check_z   <= dec.check_z;
                        bus.do_comp   <= dec.do_comp;
                        bus.check_imm <= dec.check_imm;
                        bus.imm_value <= dec.imm;
                        bus.pc_out    <= bus.pc_in;
                        bus.uop_last  <= 1'b1;
                        bus.illegal   <= dec.illegal;
                    end else begin
                        bus.out_valid <= 1'b0;
                    end
                end
                SEQ: begin
                    bus.out_valid <= 1'b1;
                    bus.opertn    <= seq_is_sm ? OP_SM : OP_LM;
                    bus.RA        <= seq_base;
                    bus.RB        <= 3'd0;
                    bus.RC        <= sel;
                    bus.check_c   <= 1'b0;
                    bus.check_z   <= 1'b0;
                    bus.do_comp   <= 1'b0;
                    bus.check_imm <= 1'b1;
                    bus.imm_value <= {{(IMM_OUT_W-3){1'b0}}, seq_k};
                    bus.pc_out    <= seq_pc;
                    bus.uop_last  <= seq_last;
                    bus.illegal   <= 1'b0;
                    seq_mask      <= mask_rest;
                    seq_k         <= seq_k + 3'd1;
                    if (seq_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decode_seq_stage.sv
module tb_decode_seq_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] instr;
    logic [15:0] pc_in;
    logic        stall;
    logic        flush;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    decode_seq_stage_if #(.PC_W(16), .IMM_OUT_W(16)) bs ();
    decode_seq_stage_if #(.PC_W(16), .IMM_OUT_W(16)) bz ();

    assign bs.in_valid = in_valid; assign bz.in_valid = in_valid;
    assign bs.instr    = instr;    assign bz.instr    = instr;
    assign bs.pc_in    = pc_in;    assign bz.pc_in    = pc_in;
    assign bs.stall    = stall;    assign bz.stall    = stall;
    assign bs.flush    = flush;    assign bz.flush    = flush;

    decode_seq_stage #(.PC_W(16), .IMM_OUT_W(16), .SEXT_IMM(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bs));
    decode_seq_stage #(.PC_W(16), .IMM_OUT_W(16), .SEXT_IMM(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .bus(bz));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; instr = 16'h1298; pc_in = 16'h0040;
        stall = 1'b0; flush = 1'b0;
        step(); step();
        check("rst_out_valid", 32'(bs.out_valid), 32'd0);
        check("rst_opertn",    32'(bs.opertn),    32'd0);
        check("rst_rc",        32'(bs.RC),        32'd0);
        check("rst_imm",       32'(bs.imm_value), 32'd0);
        check("rst_pc_out",    32'(bs.pc_out),    32'd0);
        check("rst_uop_last",  32'(bs.uop_last),  32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready",  32'(bs.in_ready),  32'd1);

        // ADA 0x1298
        step();
        check("ada_valid",   32'(bs.out_valid), 32'd1);
        check("ada_opertn",  32'(bs.opertn),    32'd1);
        check("ada_ra",      32'(bs.RA),        32'd1);
        check("ada_rb",      32'(bs.RB),        32'd2);
        check("ada_rc",      32'(bs.RC),        32'd3);
        check("ada_flags",   32'({bs.check_c, bs.check_z, bs.do_comp, bs.check_imm}), 32'd0);
        check("ada_pc",      32'(bs.pc_out),    32'h0040);
        check("ada_last",    32'(bs.uop_last),  32'd1);

        // ADI 0x023F: imm 0x3F
        instr = 16'h023F; pc_in = 16'h0042;
        step();
        check("adi_valid",   32'(bs.out_valid), 32'd1);
        check("adi_opertn",  32'(bs.opertn),    32'd0);
        check("adi_imm_s",   32'(bs.imm_value), 32'hFFFF);
        check("adi_imm_z",   32'(bz.imm_value), 32'h003F);
        check("adi_chkimm",  32'(bs.check_imm), 32'd1);
        check("adi_pc",      32'(bs.pc_out),    32'h0042);

        // JRI 0xF1FF: 9-bit imm 0x1FF
        instr = 16'hF1FF; pc_in = 16'h0044;
        step();
        check("jri_opertn",  32'(bs.opertn),    32'd25);
        check("jri_imm_s",   32'(bs.imm_value), 32'hFFFF);
        check("jri_imm_z",   32'(bz.imm_value), 32'h01FF);

        // ADC 0x129A: check carry
        instr = 16'h129A;
        step();
        check("adc_opertn",  32'(bs.opertn),    32'd2);
        check("adc_flags",   32'({bs.check_c, bs.check_z, bs.do_comp, bs.check_imm}), 32'b1000);

        // NCZ 0x229D: complement + check zero
        instr = 16'h229D;
        step();
        check("ncz_opertn",  32'(bs.opertn),    32'd14);
        check("ncz_flags",   32'({bs.check_c, bs.check_z, bs.do_comp, bs.check_imm}), 32'b0110);

        // Illegal NAND func 011
        instr = 16'h2003;
        step();
        check("ill_opertn",  32'(bs.opertn),    32'h1F);
        check("ill_flag",    32'(bs.illegal),   32'd1);
        check("ill_valid",   32'(bs.out_valid), 32'd1);
        check("ill_last",    32'(bs.uop_last),  32'd1);
        check("ill_imm",     32'(bs.imm_value), 32'd0);

        // LLI 0x3A05
        instr = 16'h3A05;
        step();
        check("lli_illegal", 32'(bs.illegal),   32'd0);
        check("lli_opertn",  32'(bs.opertn),    32'd15);
        check("lli_rc",      32'(bs.RC),        32'd5);
        check("lli_imm",     32'(bs.imm_value), 32'h0005);

        // LM 0x64A1: base R2, mask 0xA1 -> R0, R2, R7
        instr = 16'h64A1; pc_in = 16'h0050;
        step();
        in_valid = 1'b0;
        check("lm_acc_valid", 32'(bs.out_valid), 32'd0);
        check("lm_rdy0",      32'(bs.in_ready),  32'd0);
        step();
        check("lm_u0",  32'({bs.out_valid, bs.opertn, bs.RA, bs.RC, bs.uop_last}),
              32'({1'b1, 5'd18, 3'd2, 3'd0, 1'b0}));
        check("lm_u0_imm",  32'(bs.imm_value), 32'd0);
        check("lm_u0_pc",   32'(bs.pc_out),    32'h0050);
        check("lm_u0_ci",   32'(bs.check_imm), 32'd1);
        check("lm_rdy1",    32'(bs.in_ready),  32'd0);
        step();
        check("lm_u1",  32'({bs.out_valid, bs.RA, bs.RC, bs.uop_last}), 32'({1'b1, 3'd2, 3'd2, 1'b0}));
        check("lm_u1_imm",  32'(bs.imm_value), 32'd1);
        check("lm_rdy2",    32'(bs.in_ready),  32'd0);
        step();
        check("lm_u2",  32'({bs.out_valid, bs.RA, bs.RC, bs.uop_last}), 32'({1'b1, 3'd2, 3'd7, 1'b1}));
        check("lm_u2_imm",  32'(bs.imm_value), 32'd2);
        check("lm_rdy3",    32'(bs.in_ready),  32'd1);
        step();
        check("lm_idle_valid", 32'(bs.out_valid), 32'd0);

        // SM with stall on 2nd micro-op, then flush
        in_valid = 1'b1; instr = 16'h74A1; pc_in = 16'h0060;
        step();
        in_valid = 1'b0;
        step();
        check("sm_u0_opertn", 32'(bs.opertn), 32'd19);
        step();
        check("sm_u1_rc", 32'(bs.RC), 32'd2);
        stall = 1'b1;
        #1;
        check("stall_rdy", 32'(bs.in_ready), 32'd0);
        step();
        check("stall1", 32'({bs.out_valid, bs.RC, bs.imm_value[2:0], bs.uop_last}),
              32'({1'b1, 3'd2, 3'd1, 1'b0}));
        step();
        check("stall2", 32'({bs.out_valid, bs.RC, bs.imm_value[2:0], bs.uop_last}),
              32'({1'b1, 3'd2, 3'd1, 1'b0}));
        stall = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 32'(bs.out_valid), 32'd0);
        check("flush_rdy",   32'(bs.in_ready),  32'd1);
        check("flush_hold_rc", 32'(bs.RC),      32'd2);

        // LM with empty mask: no micro-op
        in_valid = 1'b1; instr = 16'h6400;
        step();
        check("m0_valid", 32'(bs.out_valid), 32'd0);
        check("m0_rdy",   32'(bs.in_ready),  32'd1);

        // Flush alongside in_valid discards the instruction
        instr = 16'h1298; pc_in = 16'h0070; flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_in_valid", 32'(bs.out_valid), 32'd0);
        step();
        check("after_flush_op", 32'({bs.out_valid, bs.opertn}), 32'({1'b1, 5'd1}));
        check("after_flush_pc", 32'(bs.pc_out), 32'h0070);

        // Reset in the middle of a sequence
        instr = 16'h64A1;
        step();
        in_valid = 1'b0;
        step();
        check("mid_seq_valid", 32'(bs.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bs.out_valid), 32'd0);
        check("mid_rst_ra",    32'(bs.RA),        32'd0);
        check("mid_rst_rdy",   32'(bs.in_ready),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_seq_stage.md
Name: decode_seq_stage

Overview:
- Next-generation decode stage of the 6-stage 16-bit pipeline, sitting between fetch and register-read.
- Registers decoded control fields for the existing ISA and adds a valid/ready handshake, stall and flush.
- Supports parametrised PC and immediate widths and selectable immediate sign-extension.
- Adds a multi-cycle LM/SM sequencer that expands one load-multiple or store-multiple instruction into one micro-op per selected register.

Parameters:
PC_W, 16, width of pc_in/pc_out
IMM_OUT_W, 16, width of imm_value (must be >= 9)
SEXT_IMM, 1, 1: sign-extend immediates; 0: zero-extend

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents instr/pc_in
in_ready  out  1  stage accepts; combinational = !stall && state==IDLE
instr  in  16  instruction word
pc_in  in  PC_W  PC of instr
stall  in  1  downstream hold; all output registers keep their values
flush  in  1  kill the in-flight instruction/sequence
out_valid  out  1  outputs carry a valid (micro-)op
opertn  out  5  operation code (ADI=0 … JRI=25, existing encoding); 0x1F = illegal
RA, RB, RC  out  3 each  source A, source B, destination
check_c, check_z, do_comp, check_imm  out  1 each  control flags as in current ISA decode
imm_value  out  IMM_OUT_W  extended immediate, or LM/SM offset
pc_out  out  PC_W  PC of the op
uop_last  out  1  last (or only) micro-op of this instruction
illegal  out  1  undefined opcode/func

Behaviour:
- Reset (async, rst_n=0): out_valid=0, all other outputs 0, state=IDLE. Outputs are registered.
- Priority per cycle: flush > stall > accept/sequence.
  - flush: out_valid<=0, state<=IDLE, other outputs unchanged. Flush in the same cycle as in_valid discards that instruction.
  - stall (no flush): every output and state register holds.
- IDLE accept (in_valid && in_ready): one-cycle latency; next edge loads decoded fields, out_valid=1, pc_out=pc_in.
- IDLE with no accept: out_valid<=0.
- Field decode: op=instr[15:12], r1=[11:9], r2=[8:6], r3=[5:3], func=[2:0].
  - ADD/NAND family (0001/0010): RA=r1, RB=r2, RC=r3; func selects variant and flags exactly as the existing ISA table.
  - NAND func 011/111: illegal.
- Immediates:
  - ADI, LLI, LW, SW, BEQ, BLT, BLE, JLR: 6-bit instr[5:0].
  - JAL (1100) and JRI (1111): 9-bit instr[8:0].
  - Extension per SEXT_IMM.
  - check_imm=1 for ADI, LLI, LW, SW, JAL, JRI.
- Illegal (op 1011/1110, bad func): opertn=0x1F, illegal=1, flags 0, imm 0, out_valid=1, uop_last=1.
- LM (0110) / SM (0111): base register=r1, mask=instr[7:0]; mask bit (7-i) selects Ri.
  - IDLE→SEQ on accept when the mask has at least one bit set.
  - Each non-stalled cycle in SEQ emits one micro-op for the next set bit, ascending i: opertn=LM/SM, RA=r1, RC=i, check_imm=1, imm_value=k (k = 0,1,2… count of ops already emitted).
  - First micro-op appears 1 cycle after accept.
  - uop_last=1 on the final micro-op; SEQ→IDLE on that same edge, so in_ready=1 in the following cycle.
  - in_ready=0 throughout SEQ.
  - Mask 0x00: no micro-op; out_valid<=0; stays IDLE.
- Back-to-back: a new instruction can be accepted every cycle in IDLE. out_valid stays 1 continuously with no bubble.
- Reset mid-sequence: immediate return to IDLE, outputs cleared.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0 and all outputs 0. After release, in_ready=1.
- ADA: instr=0x1298, pc_in=0x0040 → next cycle opertn=1, RA=1, RB=2, RC=3, all flags 0, pc_out=0x0040, uop_last=1.
- Immediate extension: ADI instr=0x023F with SEXT_IMM=1 → imm_value=0xFFFF, check_imm=1; with SEXT_IMM=0 → 0x003F. JRI instr=0xF1FF (SEXT_IMM=1) → imm_value=0xFFFF.
- LM: instr=0x64A1 → 3 consecutive micro-ops with RC=0,2,7, imm=0,1,2, RA=2, uop_last only on the third. in_ready=0 for 3 cycles, then 1.
- Stall/flush: stall asserted on the 2nd LM micro-op for 2 cycles → outputs frozen (RC=2). Then flush → out_valid=0 next cycle, in_ready=1.
- Illegal: instr=0x2003 → opertn=0x1F, illegal=1, out_valid=1. Next accepted instr=0x3A05 (LLI) → illegal=0, RC=5, imm_value=0x0005.
